// File: rtl/calc_pkg.sv
// Shared sizes and FSM encoding for the MAC sequencer.
package calc_pkg;
   localparam int NUM_OUTPUTS = 10;
   localparam int NUM_PAIRS   = 392;
   localparam int PIXEL_AW    = 10;
   localparam int WEIGHT_AW   = 12;
   localparam int OUT_AW      = 4;

   typedef enum logic [2:0] {IDLE, CLEAR, FETCH, DRAIN, STORE} state_t;
endpackage

// File: rtl/calc_addr_gen.sv
// Pixel index counter and running weight-base accumulator for the sequencer.
module calc_addr_gen
   import calc_pkg::*;
(
   input  logic                 clk,
   input  logic                 n_rst,
   input  logic                 clear,
   input  logic                 adv_index,
   input  logic                 adv_neuron,
   output logic [PIXEL_AW-1:0]  index,
   output logic [WEIGHT_AW-1:0] base,
   output logic                 last_index
);
   assign last_index = (index == PIXEL_AW'(NUM_PAIRS - 1));

   // Base steps by NUM_PAIRS per neuron, so n*392 is never multiplied out.
   always_ff @(posedge clk) begin
      if (!n_rst || clear) begin
         index <= '0;
         base  <= '0;
      end else if (adv_neuron) begin
         base  <= base + WEIGHT_AW'(NUM_PAIRS);
         index <= '0;
      end else if (adv_index) begin
         index <= last_index ? '0 : index + PIXEL_AW'(1);
      end
   end
endmodule

// File: rtl/calc_sequencer.sv
// Walks all output neurons, streaming pixel/weight pairs into the external MAC
// and writing each accumulated sum to the result register file.
module calc_sequencer
   import calc_pkg::*;
#(
   parameter int MEM_LATENCY = 1
) (
   input  logic                 clk,
   input  logic                 n_rst,
   input  logic                 start_calc,
   input  logic                 clear_data,
   input  logic                 mac_overflow,
   output logic                 mem_read,
   output logic [PIXEL_AW-1:0]  pixel_address,
   output logic [WEIGHT_AW-1:0] weight_address,
   output logic                 mac_clear,
   output logic                 mac_en,
   output logic                 result_write,
   output logic [OUT_AW-1:0]    output_address,
   output logic                 busy,
   output logic                 done_calc,
   output logic                 overflow
);
   state_t                 state, next_state;
   logic [OUT_AW-1:0]      neuron;
   logic [1:0]             drain_cnt;
   logic [MEM_LATENCY-1:0] mac_pipe;
   logic [PIXEL_AW-1:0]    index;
   logic [WEIGHT_AW-1:0]   base;
   logic                   last_index, last_neuron, drain_end, start_ok;

   assign last_neuron = (neuron == OUT_AW'(NUM_OUTPUTS - 1));
   assign drain_end   = (drain_cnt == 2'(MEM_LATENCY - 1));
   assign start_ok    = (state == IDLE) && start_calc && !clear_data;

   calc_addr_gen u_addr (
      .clk        (clk),
      .n_rst      (n_rst),
      .clear      (clear_data || state == IDLE),
      .adv_index  (state == FETCH),
      .adv_neuron (state == STORE && !last_neuron),
      .index      (index),
      .base       (base),
      .last_index (last_index)
   );

   always_ff @(posedge clk) begin
      if (!n_rst || clear_data) state <= IDLE;
      else                      state <= next_state;
   end

   always_comb begin
      next_state = state;
      case (state)
         IDLE:    if (start_calc) next_state = CLEAR;
         CLEAR:   next_state = FETCH;
         FETCH:   if (last_index) next_state = DRAIN;
         DRAIN:   if (drain_end) next_state = STORE;
         STORE:   next_state = last_neuron ? IDLE : CLEAR;
         default: next_state = IDLE;
      endcase
   end

   // Addresses are forced to zero outside FETCH so idle outputs read as all-zero.
   always_comb begin
      mem_read       = 1'b0;
      pixel_address  = '0;
      weight_address = '0;
      mac_clear      = 1'b0;
      result_write   = 1'b0;
      output_address = '0;
      busy           = (state != IDLE);
      case (state)
         CLEAR: mac_clear = 1'b1;
         FETCH: begin
            mem_read       = 1'b1;
            pixel_address  = index;
            weight_address = base + WEIGHT_AW'(index);
         end
         STORE: begin
            result_write   = 1'b1;
            output_address = neuron;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!n_rst || clear_data || state == IDLE) neuron <= '0;
      else if (state == STORE && !last_neuron)   neuron <= neuron + OUT_AW'(1);
   end

   always_ff @(posedge clk) begin
      if (!n_rst || state != DRAIN) drain_cnt <= '0;
      else                          drain_cnt <= drain_cnt + 2'd1;
   end

   // mac_en tracks mem_read through the memory read latency.
   always_ff @(posedge clk) begin
      if (!n_rst || clear_data) begin
         mac_pipe <= '0;
      end else begin
         mac_pipe[0] <= mem_read;
         for (int i = 1; i < MEM_LATENCY; i++) mac_pipe[i] <= mac_pipe[i-1];
      end
   end
   assign mac_en = mac_pipe[MEM_LATENCY-1];

   always_ff @(posedge clk) begin
      if (!n_rst || clear_data || start_ok)  done_calc <= 1'b0;
      else if (state == STORE && last_neuron) done_calc <= 1'b1;
   end

   always_ff @(posedge clk) begin
      if (!n_rst || clear_data || start_ok)               overflow <= 1'b0;
      else if (mac_overflow && (mac_en || result_write)) overflow <= 1'b1;
   end
endmodule

// File: tb/tb_calc_sequencer.sv
// Self-checking bench: behavioural memories and MAC, golden dot products, directed runs.
module tb_calc_sequencer;
   import calc_pkg::*;

   logic clk = 1'b0, n_rst = 1'b0, start_calc = 1'b0, clear_data = 1'b0, mac_overflow = 1'b0;
   logic mem_read, mac_clear, mac_en, result_write, busy, done_calc, overflow;
   logic [PIXEL_AW-1:0]  pixel_address;
   logic [WEIGHT_AW-1:0] weight_address;
   logic [OUT_AW-1:0]    output_address;

   calc_sequencer #(.MEM_LATENCY(1)) dut (
      .clk(clk), .n_rst(n_rst), .start_calc(start_calc), .clear_data(clear_data),
      .mac_overflow(mac_overflow), .mem_read(mem_read), .pixel_address(pixel_address),
      .weight_address(weight_address), .mac_clear(mac_clear), .mac_en(mac_en),
      .result_write(result_write), .output_address(output_address), .busy(busy),
      .done_calc(done_calc), .overflow(overflow)
   );

   always #5 clk = ~clk;

   logic [32:0] all_out;
   assign all_out = {mem_read, pixel_address, weight_address, mac_clear, mac_en,
                     result_write, output_address, busy, done_calc, overflow};

   // Behavioural memories (1-cycle read) and MAC accumulator.
   logic [15:0] pix_mem [NUM_PAIRS];
   logic [15:0] w_mem   [NUM_OUTPUTS*NUM_PAIRS];
   logic [63:0] gold    [NUM_OUTPUTS];
   logic [63:0] res     [NUM_OUTPUTS];
   logic [15:0] rd_p, rd_w;
   logic [63:0] acc;

   always @(posedge clk) begin
      if (mem_read) begin
         rd_p <= pix_mem[pixel_address];
         rd_w <= w_mem[weight_address];
      end
      if (mac_clear)   acc <= 64'd0;
      else if (mac_en) acc <= acc + 64'(rd_p) * 64'(rd_w);
      if (result_write) res[output_address] <= acc;
   end

   int total = 0, bad = 0;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   int r_first_idle, r_mac, r_rw, r_w3, r_wlast, r_post, r_ovf_drop;
   logic r_busy0, r_done0, r_ovf0, r_done_end, r_ovf_end;
   logic [32:0] r_zero;

   // Starts a run and observes 3951 cycles (j = cycles after the sampling edge).
   task automatic run(input int ovf_n, input int poke_start, input int abort_at, input int rst_at);
      bit inj = 0, seen3 = 0, ovf_hi = 0;
      int nwr = 0;
      r_first_idle = -1; r_mac = 0; r_rw = 0; r_w3 = -1; r_wlast = -1; r_post = 0;
      r_ovf_drop = 0; r_zero = '1;
      start_calc = 1'b1;
      @(negedge clk);
      start_calc = 1'b0;
      for (int j = 0; j <= 3950; j++) begin
         if (j == 0) begin r_busy0 = busy; r_done0 = done_calc; r_ovf0 = overflow; end
         if (!busy && r_first_idle < 0) r_first_idle = j;
         if (mac_en) r_mac++;
         if (mem_read) begin
            if (nwr == 3 && !seen3) begin r_w3 = int'(weight_address); seen3 = 1; end
            r_wlast = int'(weight_address);
         end
         if (result_write) begin
            chk("out_addr_order", 64'(output_address), 64'(nwr));
            nwr++; r_rw++;
         end
         if (abort_at >= 0 && j > abort_at && (mem_read || mac_en || result_write)) r_post++;
         if ((abort_at >= 0 && j == abort_at + 1) || (rst_at >= 0 && j == rst_at + 1)) r_zero = all_out;
         if (overflow) ovf_hi = 1; else if (ovf_hi) r_ovf_drop++;
         mac_overflow = (ovf_n >= 0 && !inj && mac_en && nwr == ovf_n);
         if (mac_overflow) inj = 1;
         start_calc = (j == poke_start);
         clear_data = (j == abort_at);
         n_rst      = (j != rst_at);
         if (j < 3950) @(negedge clk);
      end
      r_done_end = done_calc; r_ovf_end = overflow;
      mac_overflow = 1'b0; start_calc = 1'b0; clear_data = 1'b0; n_rst = 1'b1;
   endtask

   task automatic check_full(input string tag, input logic exp_ovf);
      chk({tag, ".busy0"}, 64'(r_busy0), 64'd1);
      chk({tag, ".done0"}, 64'(r_done0), 64'd0);
      chk({tag, ".idle_at"}, 64'(r_first_idle), 64'd3950);
      chk({tag, ".mac_cnt"}, 64'(r_mac), 64'(NUM_OUTPUTS * NUM_PAIRS));
      chk({tag, ".rw_cnt"}, 64'(r_rw), 64'(NUM_OUTPUTS));
      chk({tag, ".w3_first"}, 64'(r_w3), 64'd1176);
      chk({tag, ".w_last"}, 64'(r_wlast), 64'd3919);
      chk({tag, ".done_end"}, 64'(r_done_end), 64'd1);
      chk({tag, ".ovf_end"}, 64'(r_ovf_end), 64'(exp_ovf));
      for (int n = 0; n < NUM_OUTPUTS; n++) chk($sformatf("%s.result%0d", tag, n), res[n], gold[n]);
   endtask

   initial begin
      for (int i = 0; i < NUM_PAIRS; i++) pix_mem[i] = 16'($urandom);
      for (int i = 0; i < NUM_OUTPUTS * NUM_PAIRS; i++) w_mem[i] = 16'($urandom);
      for (int n = 0; n < NUM_OUTPUTS; n++) begin
         gold[n] = 64'd0;
         for (int i = 0; i < NUM_PAIRS; i++)
            gold[n] += 64'(pix_mem[i]) * 64'(w_mem[n * NUM_PAIRS + i]);
      end

      // Reset held two cycles with a start pulse that must be ignored.
      n_rst = 1'b0; start_calc = 1'b1;
      @(negedge clk); @(negedge clk);
      chk("reset.outputs", 64'(all_out), 64'd0);
      start_calc = 1'b0; n_rst = 1'b1;
      @(negedge clk);
      chk("reset.start_ignored", 64'(busy), 64'd0);

      run(-1, -1, -1, -1);
      check_full("runA", 1'b0);

      run(-1, -1, -1, -1);
      check_full("backtoback", 1'b0);

      mac_overflow = 1'b1; @(negedge clk); mac_overflow = 1'b0; @(negedge clk);
      chk("idle_ovf.ignored", 64'(overflow), 64'd0);
      chk("idle_ovf.done_held", 64'(done_calc), 64'd1);

      run(4, 100, -1, -1);
      check_full("ovf_run", 1'b1);
      chk("ovf_run.held", 64'(r_ovf_drop), 64'd0);

      run(-1, -1, 1000, -1);
      chk("restart.ovf_cleared", 64'(r_ovf0), 64'd0);
      chk("abort.idle_at", 64'(r_first_idle), 64'd1001);
      chk("abort.outputs_zero", 64'(r_zero), 64'd0);
      chk("abort.no_activity", 64'(r_post), 64'd0);
      chk("abort.rw_cnt", 64'(r_rw), 64'd2);
      chk("abort.done_end", 64'(r_done_end), 64'd0);

      clear_data = 1'b1; start_calc = 1'b1;
      @(negedge clk);
      clear_data = 1'b0; start_calc = 1'b0;
      chk("clear_beats_start", 64'(busy), 64'd0);
      @(negedge clk);
      chk("clear_beats_start.stay", 64'(busy), 64'd0);

      run(-1, -1, -1, 500);
      chk("midreset.outputs_zero", 64'(r_zero), 64'd0);
      chk("midreset.idle_at", 64'(r_first_idle), 64'd501);

      run(-1, -1, -1, -1);
      check_full("after_reset", 1'b0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
